// File: rtl/char_buf_ram.sv
`default_nettype none
// ============================================================================
// Module  : char_buf_ram
// Purpose : Writable COLS x ROWS character buffer, self-filled from TEXT,
//           with registered read port for the character renderer.
// Revision: 1.0 - initial release
// ============================================================================
module char_buf_ram #(
    parameter int         COLS      = 16,
    parameter int         ROWS      = 16,
    parameter             TEXT      = "Basic text",
    parameter int         TEXT_LEN  = 10,
    parameter logic [6:0] FILL_CHAR = 7'h20,
    parameter int         X_W       = (COLS > 1) ? $clog2(COLS) : 1,
    parameter int         Y_W       = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [X_W-1:0] rd_x,
    input  logic [Y_W-1:0] rd_y,
    output logic [6:0]     char_code,
    input  logic           wr_valid,
    output logic           wr_ready,
    input  logic [X_W-1:0] wr_x,
    input  logic [Y_W-1:0] wr_y,
    input  logic [6:0]     wr_char,
    input  logic           clr_req,
    input  logic           reload_req,
    output logic           busy,
    output logic           wr_err
);

    localparam int c_N          = COLS * ROWS;
    localparam int c_IDX_W      = X_W + Y_W + 1;
    localparam int c_ADDR_W     = (c_N > 1) ? $clog2(c_N) : 1;
    localparam int c_TEXT_BYTES = $bits(TEXT) / 8;

    localparam logic [c_IDX_W-1:0] c_COLS = c_IDX_W'(COLS);
    localparam logic [c_IDX_W-1:0] c_ROWS = c_IDX_W'(ROWS);
    localparam logic [c_IDX_W-1:0] c_NUM  = c_IDX_W'(c_N);
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(c_N - 1);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [c_IDX_W-1:0]  r_cnt;
    logic [c_IDX_W-1:0]  w_next_cnt;
    logic [6:0]          r_mem [0:c_N-1];

    logic                w_mem_we;
    logic [c_ADDR_W-1:0] w_mem_addr;
    logic [6:0]          w_mem_data;
    logic                w_err_next;

    logic [c_IDX_W-1:0]  w_rd_idx;
    logic [c_IDX_W-1:0]  w_wr_idx;
    logic                w_rd_ok;
    logic                w_wr_ok;

    // Leftmost TEXT character is cell 0; cells past TEXT_LEN take FILL_CHAR.
    function automatic logic [6:0] f_text_char(input logic [c_IDX_W-1:0] i);
        logic [6:0] ch;
        ch = FILL_CHAR;
        for (int k = 0; k < TEXT_LEN; k++) begin
            if (i == c_IDX_W'(k)) begin
                ch = TEXT[8*(c_TEXT_BYTES-1-k) +: 7];
            end
        end
        return ch;
    endfunction

    assign w_rd_idx = c_IDX_W'(rd_y) * c_COLS + c_IDX_W'(rd_x);
    assign w_wr_idx = c_IDX_W'(wr_y) * c_COLS + c_IDX_W'(wr_x);
    assign w_rd_ok  = (c_IDX_W'(rd_x) < c_COLS) && (c_IDX_W'(rd_y) < c_ROWS) && (w_rd_idx < c_NUM);
    assign w_wr_ok  = (c_IDX_W'(wr_x) < c_COLS) && (c_IDX_W'(wr_y) < c_ROWS) && (w_wr_idx < c_NUM);

    assign busy     = (r_state != ST_IDLE);
    assign wr_ready = (r_state == ST_IDLE) && !clr_req && !reload_req;

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_mem_we     = 1'b0;
        w_mem_addr   = r_cnt[c_ADDR_W-1:0];
        w_mem_data   = FILL_CHAR;
        w_err_next   = 1'b0;
        case (r_state)
            ST_INIT, ST_CLEAR: begin
                w_mem_we   = 1'b1;
                w_mem_data = (r_state == ST_INIT) ? f_text_char(r_cnt) : FILL_CHAR;
                if (r_cnt == c_LAST) begin
                    w_next_state = ST_IDLE;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt   = r_cnt + c_IDX_W'(1);
                end
            end
            ST_IDLE: begin
                // Reload takes priority over clear when both arrive together.
                if (reload_req) begin
                    w_next_state = ST_INIT;
                    w_next_cnt   = '0;
                end else if (clr_req) begin
                    w_next_state = ST_CLEAR;
                    w_next_cnt   = '0;
                end else if (wr_valid) begin
                    if (w_wr_ok) begin
                        w_mem_we   = 1'b1;
                        w_mem_addr = w_wr_idx[c_ADDR_W-1:0];
                        w_mem_data = wr_char;
                    end else begin
                        w_err_next = 1'b1;
                    end
                end
            end
            default: begin
                w_next_state = ST_INIT;
                w_next_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_INIT;
            r_cnt     <= '0;
            char_code <= 7'h00;
            wr_err    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_cnt     <= w_next_cnt;
            wr_err    <= w_err_next;
            char_code <= w_rd_ok ? r_mem[w_rd_idx[c_ADDR_W-1:0]] : FILL_CHAR;
        end
    end

    // Memory has no reset; the INIT pass after reset rewrites every cell.
    always_ff @(posedge clk) begin
        if (rst_n && w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_char_buf_ram.sv
`default_nettype none
// ============================================================================
// Module  : tb_char_buf_ram
// Purpose : Self-checking bench for char_buf_ram (4x2 buffer, TEXT "AB").
// Revision: 1.0 - initial release
// ============================================================================
module tb_char_buf_ram;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] rd_x, wr_x;
    logic [1:0] rd_y, wr_y;
    logic [6:0] char_code, wr_char;
    logic       wr_valid, wr_ready, clr_req, reload_req, busy, wr_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    char_buf_ram #(
        .COLS(4), .ROWS(2), .TEXT("AB"), .TEXT_LEN(2),
        .FILL_CHAR(7'h20), .X_W(2), .Y_W(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_x(rd_x), .rd_y(rd_y), .char_code(char_code),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_x(wr_x), .wr_y(wr_y), .wr_char(wr_char),
        .clr_req(clr_req), .reload_req(reload_req),
        .busy(busy), .wr_err(wr_err)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a cell array plus "fill pass in progress" bookkeeping.
    int m_mem   [8];
    bit m_known [8];
    int m_text  [2] = '{'h41, 'h42};
    bit m_started = 1'b0;
    bit m_fill, m_fill_text, m_err, m_char_known;
    int m_pos, m_char;
    int nc;
    bit nk;
    bit ne;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_started    = 1'b1;
            m_fill       = 1'b1;
            m_fill_text  = 1'b1;
            m_pos        = 0;
            m_char       = 0;
            m_char_known = 1'b1;
            m_err        = 1'b0;
        end else if (m_started) begin
            if (rd_x < 4 && rd_y < 2) begin
                nc = m_mem[rd_y*4 + rd_x];
                nk = m_known[rd_y*4 + rd_x];
            end else begin
                nc = 'h20;
                nk = 1'b1;
            end
            ne = 1'b0;
            if (m_fill) begin
                m_mem[m_pos]   = (m_fill_text && m_pos < 2) ? m_text[m_pos] : 'h20;
                m_known[m_pos] = 1'b1;
                m_pos++;
                if (m_pos == 8) m_fill = 1'b0;
            end else if (reload_req) begin
                m_fill = 1'b1; m_fill_text = 1'b1; m_pos = 0;
            end else if (clr_req) begin
                m_fill = 1'b1; m_fill_text = 1'b0; m_pos = 0;
            end else if (wr_valid) begin
                if (wr_x < 4 && wr_y < 2) begin
                    m_mem[wr_y*4 + wr_x]   = int'(wr_char);
                    m_known[wr_y*4 + wr_x] = 1'b1;
                end else begin
                    ne = 1'b1;
                end
            end
            m_char       = nc;
            m_char_known = nk;
            m_err        = ne;
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("busy", int'(busy), int'(m_fill));
            chk("wr_ready", int'(wr_ready), int'(!m_fill && !clr_req && !reload_req));
            chk("wr_err", int'(wr_err), int'(m_err));
            if (m_char_known) chk("char_code", int'(char_code), m_char);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int x, input int y, output int code);
        rd_x = 2'(x);
        rd_y = 2'(y);
        tick();
        code = int'(char_code);
    endtask

    task automatic wr(input int x, input int y, input int ch, output int waited);
        wr_valid = 1'b1;
        wr_x     = 2'(x);
        wr_y     = 2'(y);
        wr_char  = 7'(ch);
        waited   = 0;
        while (!wr_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (waited >= 50) chk("wr_ready_timeout", 0, 1);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        chk(name, n, 8);
    endtask

    task automatic check_init_image(input string name);
        int c;
        for (int i = 0; i < 8; i++) begin
            rd(i % 4, i / 4, c);
            chk(name, c, (i == 0) ? 'h41 : (i == 1) ? 'h42 : 'h20);
        end
    endtask

    initial begin
        int c, n;
        rst_n = 1'b0; rd_x = '0; rd_y = '0; wr_valid = 1'b0;
        wr_x = '0; wr_y = '0; wr_char = '0; clr_req = 1'b0; reload_req = 1'b0;
        tick(); tick();
        chk("reset_char_code", int'(char_code), 0);
        chk("reset_busy", int'(busy), 1);
        rst_n = 1'b1;
        wait_idle("init_busy_cycles");
        check_init_image("init_cell");

        // Write, with a read of the same cell on the accepting edge.
        rd_x = 2'd3; rd_y = 2'd1;
        wr(3, 1, 'h5A, n);
        chk("write_wait", n, 0);
        chk("read_first_old", int'(char_code), 'h20);
        chk("wr_err_in_range", int'(wr_err), 0);
        rd(3, 1, c);
        chk("write_read_back", c, 'h5A);

        // Out-of-range write.
        wr(3, 2, 'h77, n);
        chk("wr_err_pulse", int'(wr_err), 1);
        tick();
        chk("wr_err_one_cycle", int'(wr_err), 0);
        rd(0, 2, c);
        chk("oor_read_fill", c, 'h20);
        rd(3, 0, c);
        chk("oor_no_alias", c, 'h20);
        rd(3, 1, c);
        chk("oor_keeps_cell", c, 'h5A);

        // Clear.
        clr_req = 1'b1;
        #1 chk("clr_drops_ready", int'(wr_ready), 0);
        tick();
        clr_req = 1'b0;
        wait_idle("clear_busy_cycles");
        for (int i = 0; i < 8; i++) begin
            rd(i % 4, i / 4, c);
            chk("clear_cell", c, 'h20);
        end

        // Reload.
        reload_req = 1'b1;
        tick();
        reload_req = 1'b0;
        wait_idle("reload_busy_cycles");
        check_init_image("reload_cell");

        // Clear and reload together: reload wins.
        wr(0, 0, 'h11, n);
        clr_req = 1'b1; reload_req = 1'b1;
        tick();
        clr_req = 1'b0; reload_req = 1'b0;
        wait_idle("both_busy_cycles");
        rd(0, 0, c);
        chk("both_reload_wins", c, 'h41);

        // Backpressure during clear.
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        wr(1, 0, 'h31, n);
        chk("bp_wait_cycles", n, 8);
        rd(1, 0, c);
        chk("bp_read_back", c, 'h31);

        // Reset three cycles into a clear.
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        wait_idle("reset_mid_clear_cycles");
        check_init_image("reset_mid_clear_cell");

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rd_x       = 2'($urandom_range(0, 3));
            rd_y       = 2'($urandom_range(0, 3));
            wr_valid   = 1'($urandom_range(0, 1));
            wr_x       = 2'($urandom_range(0, 3));
            wr_y       = 2'($urandom_range(0, 3));
            wr_char    = 7'($urandom_range(0, 127));
            clr_req    = ($urandom_range(0, 39) == 0);
            reload_req = ($urandom_range(0, 59) == 0);
            rst_n      = ($urandom_range(0, 249) != 0);
            tick();
        end
        wr_valid = 1'b0; clr_req = 1'b0; reload_req = 1'b0; rst_n = 1'b1;
        repeat (20) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
